sprite_cmd_encoder: RTL

Host-side transmitter for the sprite command word consumed by the sprite display blocks: it accepts per-sprite update requests over a valid/ready handshake and packs them into 32-bit command words. It queues the words in a small FIFO and issues them one per cycle on `writedata`. On a host commit it inserts the buffer-flip (flush) command at the next vertical-blank edge. It sits between the Avalon-side register logic and the `writedata` input of every display block on the shared command bus.

---
 rtl/sprite_cmd_encoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sprite_cmd_encoder.sv
// Sprite command-word transmitter: packs update requests into a FIFO and inserts buffer-flip words at vblank.
// Optional SPRITE_CMD_ENCODER_DROPCNT_EN implements the saturating rejected-request counter.
module sprite_cmd_encoder #(
    parameter logic [5:0] DEVICE_ID   = 6'b001001,
    parameter int         MAX_SPRITES = 2,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [9:0] VBLANK_LINE = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_sprite_id,
    input  logic        req_visible,
    input  logic        req_flip,
    input  logic        req_pattern_en,
    input  logic [9:0]  req_data,
    input  logic        frame_commit,
    input  logic [9:0]  vcount,
    output logic [31:0] writedata,
    output logic        write,
    output logic        cur_buffer,
    output logic        commit_ack,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, COMMIT_WAIT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, pre_cnt_q, pre_cnt_d;
    logic            pend_q, pend_d;
    logic [9:0]      vprev_q;
    logic [31:0]     wdata_q, wdata_d;
    logic            write_q, write_d, cur_buf_q, cur_buf_d, ack_q, ack_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            accept, id_ok, push, pop, vb_edge, in_flush, go_flush;
    logic [31:0]     new_word;

    always_comb begin
        req_ready = reset && (count_q != CW'(FIFO_DEPTH));
        accept    = req_valid && req_ready;
        id_ok     = int'(req_sprite_id) < MAX_SPRITES;
        push      = accept && id_ok;
        vb_edge   = (vcount == VBLANK_LINE) && (vprev_q != VBLANK_LINE);
        in_flush  = (state_q == FLUSH);
        // While a commit is pending only the words queued before it may drain.
        pop       = (count_q != '0) && (!pend_q || pre_cnt_q != '0) && !in_flush;
        go_flush  = pend_q && (pre_cnt_q == '0) && vb_edge && !in_flush;
        new_word  = {DEVICE_ID, req_sprite_id, 4'h1, (req_pattern_en ? 3'b001 : 3'b000),
                     1'b0, req_visible, req_flip, 1'b0, req_data};

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);

        pend_d    = pend_q;
        pre_cnt_d = pre_cnt_q;
        if (in_flush)
            pend_d = 1'b0;
        else if (frame_commit && !pend_q) begin
            pend_d    = 1'b1;
            pre_cnt_d = count_q - CW'(pop);
        end else if (pend_q && pop)
            pre_cnt_d = pre_cnt_q - CW'(1);

        // Output register always carries a no-op unless a word is issued this cycle.
        wdata_d   = 32'h0;
        write_d   = 1'b0;
        ack_d     = 1'b0;
        cur_buf_d = cur_buf_q;
        if (in_flush) begin
            wdata_d   = {DEVICE_ID, 5'd0, 4'hF, 3'b000, ~cur_buf_q, 13'd0};
            write_d   = 1'b1;
            ack_d     = 1'b1;
            cur_buf_d = ~cur_buf_q;
        end else if (pop) begin
            wdata_d = mem_q[rd_ptr_q];
            write_d = 1'b1;
        end

        if (go_flush)
            state_d = FLUSH;
        else if (pend_d)
            state_d = (pre_cnt_d != '0) ? SEND : COMMIT_WAIT;
        else
            state_d = (count_d != '0) ? SEND : IDLE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= new_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pre_cnt_q <= '0;
            pend_q    <= 1'b0;
            vprev_q   <= '0;
            wdata_q   <= 32'h0;
            write_q   <= 1'b0;
            cur_buf_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pre_cnt_q <= pre_cnt_d;
            pend_q    <= pend_d;
            vprev_q   <= vcount;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            cur_buf_q <= cur_buf_d;
            ack_q     <= ack_d;
        end
    end

    assign writedata  = wdata_q;
    assign write      = write_q;
    assign cur_buffer = cur_buf_q;
    assign commit_ack = ack_q;

`ifdef SPRITE_CMD_ENCODER_DROPCNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = accept && !id_ok;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt_q <= 8'd0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'd0;
`endif
endmodule
